// File: rtl/gfx_pkg.sv
// gfx_pkg
// Shared definitions for the graphics ROM fetch scheduler.
//   ADDR_W      default graphics ROM address width
//   PH_PF_LOAD  pixel phase whose pix_en triggers the PF shifter load
//   PH_MO_LOAD  pixel phase whose pix_en triggers the MO shifter load
//   fetch_req_t latched fetch request {addr, flip}
package gfx_pkg;

    localparam int ADDR_W = 18;

    localparam logic [2:0] PH_PF_LOAD = 3'd3;
    localparam logic [2:0] PH_MO_LOAD = 3'd7;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              flip;
    } fetch_req_t;

endpackage

// File: rtl/gfx_fetch_sched_fetch_slot.sv
// fetch_slot
// One requester's fetch slot. On a window boundary it either takes the
// request (latch addr/flip, ack next cycle, window not blank) or records a
// blank window and flags a miss in the boundary cycle.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_bnd            window boundary pulse for this requester
//   i_req            level request
//   i_req_data       {addr, flip} presented with the request
//   o_ack            registered one-cycle acknowledge
//   o_blank          registered: current window carries no data
//   o_data           latched {addr, flip} for the current window
//   o_miss           combinational: boundary with no request (this cycle)
import gfx_pkg::*;

module fetch_slot (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_bnd,
    input  logic       i_req,
    input  fetch_req_t i_req_data,
    output logic       o_ack,
    output logic       o_blank,
    output fetch_req_t o_data,
    output logic       o_miss
);

    logic       r_ack;
    logic       r_blank;
    fetch_req_t r_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ack   <= 1'b0;
            r_blank <= 1'b1;
            r_data  <= '0;
        end else begin
            r_ack <= i_bnd & i_req;
            if (i_bnd) begin
                if (i_req) begin
                    r_data  <= i_req_data;
                    r_blank <= 1'b0;
                end else begin
                    // Keep the old address so rom_addr stays stable; the
                    // datapath loads transparent because of the blank flag.
                    r_blank <= 1'b1;
                end
            end
        end
    end

    assign o_ack   = r_ack;
    assign o_blank = r_blank;
    assign o_data  = r_data;
    assign o_miss  = i_bnd & ~i_req;

endmodule

// File: rtl/gfx_fetch_sched.sv
// gfx_fetch_sched
// Time-shares one graphics ROM address port between the playfield (PF) and
// motion-object (MO) requesters on a fixed 8-pixel window. Phases 0-3 fetch
// for PF, phases 4-7 for MO; each bank is loaded at the end of its window.
// Ports:
//   i_sysclk, i_reset             clock, synchronous active-high reset
//   i_pix_en                      one-cycle pulse per pixel
//   i_line_start                  scanline start; forces phase 0, PF boundary
//   i_pf_req/_addr/_flip, o_pf_ack  PF requester handshake
//   i_mo_req/_addr/_flip, o_mo_ack  MO requester handshake
//   o_rom_addr                    graphics ROM address (registered)
//   o_gld_b                       active-low shifter load strobe
//   o_mo_v_pf_b                   load target, 1 = MO bank, 0 = PF bank
//   o_mghf                        flip bit for the load
//   o_pf_blank, o_mo_blank        current window has no data
//   o_miss_cnt                    saturating count of request-less windows
//
// state    | meaning
// ST_IDLE  | after reset; pix_en ignored until the first line_start
// ST_RUN   | phase counter and strobes active
import gfx_pkg::*;

module gfx_fetch_sched #(
    parameter int ADDR_W  = gfx_pkg::ADDR_W,
    parameter int ROM_LAT = 2
) (
    input  logic              i_sysclk,
    input  logic              i_reset,
    input  logic              i_pix_en,
    input  logic              i_line_start,
    input  logic              i_pf_req,
    input  logic [ADDR_W-1:0] i_pf_addr,
    input  logic              i_pf_flip,
    output logic              o_pf_ack,
    input  logic              i_mo_req,
    input  logic [ADDR_W-1:0] i_mo_addr,
    input  logic              i_mo_flip,
    output logic              o_mo_ack,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_gld_b,
    output logic              o_mo_v_pf_b,
    output logic              o_mghf,
    output logic              o_pf_blank,
    output logic              o_mo_blank,
    output logic [7:0]        o_miss_cnt
);

    // The latched request type is sized by the package width.
    if (ADDR_W != gfx_pkg::ADDR_W) begin : g_bad_addr_w
        $error("ADDR_W must match gfx_pkg::ADDR_W");
    end
    if (ROM_LAT < 1) begin : g_bad_rom_lat
        $error("ROM_LAT must be at least 1");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_phase;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_gld_b;
    logic              r_mo_v_pf_b;
    logic              r_mghf;
    logic [7:0]        r_miss_cnt;

    logic       w_pix;
    logic       w_pf_strobe;
    logic       w_mo_strobe;
    logic       w_pf_bnd;
    logic       w_mo_bnd;
    logic       w_pf_miss;
    logic       w_mo_miss;
    fetch_req_t w_pf_in;
    fetch_req_t w_mo_in;
    fetch_req_t w_pf_data;
    fetch_req_t w_mo_data;

    // line_start overrides pix_en, which also aborts an in-progress MO window.
    assign w_pix       = (r_state == ST_RUN) & i_pix_en & ~i_line_start;
    assign w_pf_strobe = w_pix & (r_phase == PH_PF_LOAD);
    assign w_mo_strobe = w_pix & (r_phase == PH_MO_LOAD);
    assign w_pf_bnd    = i_line_start | w_mo_strobe;
    assign w_mo_bnd    = w_pf_strobe;

    assign w_pf_in = '{addr: i_pf_addr, flip: i_pf_flip};
    assign w_mo_in = '{addr: i_mo_addr, flip: i_mo_flip};

    fetch_slot u_pf_slot (
        .i_clk      (i_sysclk),
        .i_reset    (i_reset),
        .i_bnd      (w_pf_bnd),
        .i_req      (i_pf_req),
        .i_req_data (w_pf_in),
        .o_ack      (o_pf_ack),
        .o_blank    (o_pf_blank),
        .o_data     (w_pf_data),
        .o_miss     (w_pf_miss)
    );

    fetch_slot u_mo_slot (
        .i_clk      (i_sysclk),
        .i_reset    (i_reset),
        .i_bnd      (w_mo_bnd),
        .i_req      (i_mo_req),
        .i_req_data (w_mo_in),
        .o_ack      (o_mo_ack),
        .o_blank    (o_mo_blank),
        .o_data     (w_mo_data),
        .o_miss     (w_mo_miss)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (i_line_start) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_phase     <= 3'd0;
            r_rom_addr  <= '0;
            r_gld_b     <= 1'b1;
            r_mo_v_pf_b <= 1'b0;
            r_mghf      <= 1'b0;
            r_miss_cnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gld_b <= 1'b1;

            if (i_line_start) begin
                r_phase <= 3'd0;
            end else if (w_pix) begin
                r_phase <= r_phase + 3'd1;
            end

            // Address switches only on boundaries; a blank window keeps the
            // previously latched address of that requester.
            if (w_pf_bnd) begin
                r_rom_addr <= i_pf_req ? i_pf_addr : w_pf_data.addr;
            end else if (w_mo_bnd) begin
                r_rom_addr <= i_mo_req ? i_mo_addr : w_mo_data.addr;
            end

            // Load uses the flip latched for the window that is ending, which
            // is the pre-edge slot value even when the other slot re-latches.
            if (w_pf_strobe) begin
                r_gld_b     <= 1'b0;
                r_mo_v_pf_b <= 1'b0;
                r_mghf      <= w_pf_data.flip;
            end else if (w_mo_strobe) begin
                r_gld_b     <= 1'b0;
                r_mo_v_pf_b <= 1'b1;
                r_mghf      <= w_mo_data.flip;
            end

            // PF and MO boundaries never coincide, so at most one miss a cycle.
            if ((w_pf_miss | w_mo_miss) && (r_miss_cnt != 8'hFF)) begin
                r_miss_cnt <= r_miss_cnt + 8'd1;
            end
        end
    end

    assign o_rom_addr  = r_rom_addr;
    assign o_gld_b     = r_gld_b;
    assign o_mo_v_pf_b = r_mo_v_pf_b;
    assign o_mghf      = r_mghf;
    assign o_miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_gfx_fetch_sched.sv
module tb_gfx_fetch_sched;

    localparam int AW = 18;

    logic          clk;
    logic          rst;
    logic          pix_en;
    logic          line_start;
    logic          pf_req;
    logic [AW-1:0] pf_addr;
    logic          pf_flip;
    logic          pf_ack;
    logic          mo_req;
    logic [AW-1:0] mo_addr;
    logic          mo_flip;
    logic          mo_ack;
    logic [AW-1:0] rom_addr;
    logic          gld_b;
    logic          mo_v_pf_b;
    logic          mghf;
    logic          pf_blank;
    logic          mo_blank;
    logic [7:0]    miss_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Event counters, sampled on the falling edge.
    int strobe_cnt = 0;
    int blank_strobe_cnt = 0;
    int pf_ack_cnt = 0;
    int mo_ack_cnt = 0;

    // Outputs captured in the cycle right after a pix_en pulse.
    logic          cap_gld;
    logic          cap_mvp;
    logic          cap_mghf;
    logic          cap_pf_ack;
    logic          cap_mo_ack;
    logic [AW-1:0] cap_rom;

    gfx_fetch_sched #(.ADDR_W(AW), .ROM_LAT(2)) dut (
        .i_sysclk     (clk),
        .i_reset      (rst),
        .i_pix_en     (pix_en),
        .i_line_start (line_start),
        .i_pf_req     (pf_req),
        .i_pf_addr    (pf_addr),
        .i_pf_flip    (pf_flip),
        .o_pf_ack     (pf_ack),
        .i_mo_req     (mo_req),
        .i_mo_addr    (mo_addr),
        .i_mo_flip    (mo_flip),
        .o_mo_ack     (mo_ack),
        .o_rom_addr   (rom_addr),
        .o_gld_b      (gld_b),
        .o_mo_v_pf_b  (mo_v_pf_b),
        .o_mghf       (mghf),
        .o_pf_blank   (pf_blank),
        .o_mo_blank   (mo_blank),
        .o_miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gld_b === 1'b0) begin
            strobe_cnt++;
            if ((mo_v_pf_b === 1'b1) ? (mo_blank === 1'b1) : (pf_blank === 1'b1))
                blank_strobe_cnt++;
        end
        if (pf_ack === 1'b1) pf_ack_cnt++;
        if (mo_ack === 1'b1) mo_ack_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pixel: pix_en for one cycle, then two idle cycles (ROM_LAT+1 spacing).
    task automatic pix();
        pix_en = 1'b1;
        tick();
        pix_en = 1'b0;
        cap_gld    = gld_b;
        cap_mvp    = mo_v_pf_b;
        cap_mghf   = mghf;
        cap_pf_ack = pf_ack;
        cap_mo_ack = mo_ack;
        cap_rom    = rom_addr;
        tick();
        tick();
    endtask

    task automatic test_reset();
        int s;
        int pa;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (gld_b !== 1'b1) begin n_err++; $display("FAIL reset_gld_b: got %b want 1", gld_b); end
        n_cmp++; if (mo_v_pf_b !== 1'b0) begin n_err++; $display("FAIL reset_mo_v_pf_b: got %b want 0", mo_v_pf_b); end
        n_cmp++; if (mghf !== 1'b0) begin n_err++; $display("FAIL reset_mghf: got %b want 0", mghf); end
        n_cmp++; if (rom_addr !== 18'h0) begin n_err++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
        n_cmp++; if (pf_ack !== 1'b0) begin n_err++; $display("FAIL reset_pf_ack: got %b want 0", pf_ack); end
        n_cmp++; if (mo_ack !== 1'b0) begin n_err++; $display("FAIL reset_mo_ack: got %b want 0", mo_ack); end
        n_cmp++; if (pf_blank !== 1'b1) begin n_err++; $display("FAIL reset_pf_blank: got %b want 1", pf_blank); end
        n_cmp++; if (mo_blank !== 1'b1) begin n_err++; $display("FAIL reset_mo_blank: got %b want 1", mo_blank); end
        n_cmp++; if (miss_cnt !== 8'd0) begin n_err++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt); end
        rst = 1'b0;
        tick();
        // pix_en before the first line_start must be ignored.
        s  = strobe_cnt;
        pa = pf_ack_cnt;
        pf_req  = 1'b1;
        pf_addr = 18'h11111;
        for (int i = 0; i < 8; i++) pix();
        pf_req = 1'b0;
        n_cmp++; if (strobe_cnt !== s) begin n_err++; $display("FAIL idle_strobes: got %0d want %0d", strobe_cnt, s); end
        n_cmp++; if (pf_ack_cnt !== pa) begin n_err++; $display("FAIL idle_pf_ack: got %0d want %0d", pf_ack_cnt, pa); end
        n_cmp++; if (miss_cnt !== 8'd0) begin n_err++; $display("FAIL idle_miss_cnt: got %0d want 0", miss_cnt); end
        n_cmp++; if (rom_addr !== 18'h0) begin n_err++; $display("FAIL idle_rom_addr: got %h want 0", rom_addr); end
    endtask

    task automatic test_pf_fetch();
        int s;
        pf_req     = 1'b1;
        pf_addr    = 18'h12345;
        pf_flip    = 1'b0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        pf_req     = 1'b0;
        n_cmp++; if (pf_ack !== 1'b1) begin n_err++; $display("FAIL pf_ack_after_ls: got %b want 1", pf_ack); end
        n_cmp++; if (rom_addr !== 18'h12345) begin n_err++; $display("FAIL pf_rom_addr: got %h want 12345", rom_addr); end
        n_cmp++; if (pf_blank !== 1'b0) begin n_err++; $display("FAIL pf_blank_taken: got %b want 0", pf_blank); end
        tick();
        n_cmp++; if (pf_ack !== 1'b0) begin n_err++; $display("FAIL pf_ack_one_cycle: got %b want 0", pf_ack); end
        s = strobe_cnt;
        for (int i = 0; i < 3; i++) pix();
        n_cmp++; if (strobe_cnt !== s) begin n_err++; $display("FAIL pf_early_strobe: got %0d want %0d", strobe_cnt, s); end
        mo_req  = 1'b1;
        mo_addr = 18'h2ABCD;
        mo_flip = 1'b1;
        pix();
        mo_req = 1'b0;
        n_cmp++; if (cap_gld !== 1'b0) begin n_err++; $display("FAIL pf_strobe_gld: got %b want 0", cap_gld); end
        n_cmp++; if (cap_mvp !== 1'b0) begin n_err++; $display("FAIL pf_strobe_target: got %b want 0", cap_mvp); end
        n_cmp++; if (cap_mghf !== 1'b0) begin n_err++; $display("FAIL pf_strobe_mghf: got %b want 0", cap_mghf); end
        n_cmp++; if (cap_mo_ack !== 1'b1) begin n_err++; $display("FAIL mo_ack_ph4: got %b want 1", cap_mo_ack); end
        n_cmp++; if (cap_rom !== 18'h2ABCD) begin n_err++; $display("FAIL mo_rom_addr: got %h want 2abcd", cap_rom); end
        n_cmp++; if (strobe_cnt !== s + 1) begin n_err++; $display("FAIL pf_strobe_count: got %0d want %0d", strobe_cnt, s + 1); end
        n_cmp++; if (miss_cnt !== 8'd0) begin n_err++; $display("FAIL pf_miss_cnt: got %0d want 0", miss_cnt); end
    endtask

    task automatic test_mo_fetch();
        int s;
        s = strobe_cnt;
        for (int i = 0; i < 3; i++) pix();
        n_cmp++; if (strobe_cnt !== s) begin n_err++; $display("FAIL mo_early_strobe: got %0d want %0d", strobe_cnt, s); end
        pix();
        n_cmp++; if (cap_gld !== 1'b0) begin n_err++; $display("FAIL mo_strobe_gld: got %b want 0", cap_gld); end
        n_cmp++; if (cap_mvp !== 1'b1) begin n_err++; $display("FAIL mo_strobe_target: got %b want 1", cap_mvp); end
        n_cmp++; if (cap_mghf !== 1'b1) begin n_err++; $display("FAIL mo_strobe_mghf: got %b want 1", cap_mghf); end
        n_cmp++; if (cap_pf_ack !== 1'b0) begin n_err++; $display("FAIL mo_no_pf_ack: got %b want 0", cap_pf_ack); end
        n_cmp++; if (cap_rom !== 18'h12345) begin n_err++; $display("FAIL blank_pf_rom: got %h want 12345", cap_rom); end
        n_cmp++; if (pf_blank !== 1'b1) begin n_err++; $display("FAIL pf_blank_miss: got %b want 1", pf_blank); end
        n_cmp++; if (miss_cnt !== 8'd1) begin n_err++; $display("FAIL mo_miss_cnt: got %0d want 1", miss_cnt); end
    endtask

    task automatic test_blank_groups();
        int s;
        int b;
        int pa;
        int ma;
        s  = strobe_cnt;
        b  = blank_strobe_cnt;
        pa = pf_ack_cnt;
        ma = mo_ack_cnt;
        for (int i = 0; i < 16; i++) pix();
        n_cmp++; if (strobe_cnt !== s + 4) begin n_err++; $display("FAIL blank_strobes: got %0d want %0d", strobe_cnt, s + 4); end
        n_cmp++; if (blank_strobe_cnt !== b + 4) begin n_err++; $display("FAIL blank_flagged: got %0d want %0d", blank_strobe_cnt, b + 4); end
        n_cmp++; if (pf_ack_cnt !== pa) begin n_err++; $display("FAIL blank_pf_acks: got %0d want %0d", pf_ack_cnt, pa); end
        n_cmp++; if (mo_ack_cnt !== ma) begin n_err++; $display("FAIL blank_mo_acks: got %0d want %0d", mo_ack_cnt, ma); end
        n_cmp++; if (miss_cnt !== 8'd5) begin n_err++; $display("FAIL blank_miss_cnt: got %0d want 5", miss_cnt); end
    endtask

    task automatic test_line_start_abort();
        int s;
        int ma;
        logic [7:0] m;
        for (int i = 0; i < 3; i++) pix();
        mo_req  = 1'b1;
        mo_addr = 18'h15555;
        mo_flip = 1'b0;
        pix();
        mo_req = 1'b0;
        n_cmp++; if (cap_mo_ack !== 1'b1) begin n_err++; $display("FAIL abort_mo_ack: got %b want 1", cap_mo_ack); end
        pix();
        // Phase is now 5, inside the MO window.
        s  = strobe_cnt;
        ma = mo_ack_cnt;
        m  = miss_cnt;
        pf_req     = 1'b1;
        pf_addr    = 18'h0AAAA;
        pf_flip    = 1'b1;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        pf_req     = 1'b0;
        n_cmp++; if (pf_ack !== 1'b1) begin n_err++; $display("FAIL abort_pf_ack: got %b want 1", pf_ack); end
        n_cmp++; if (rom_addr !== 18'h0AAAA) begin n_err++; $display("FAIL abort_rom_addr: got %h want 0aaaa", rom_addr); end
        n_cmp++; if (gld_b !== 1'b1) begin n_err++; $display("FAIL abort_gld_b: got %b want 1", gld_b); end
        tick();
        for (int i = 0; i < 3; i++) pix();
        n_cmp++; if (strobe_cnt !== s) begin n_err++; $display("FAIL abort_no_mo_strobe: got %0d want %0d", strobe_cnt, s); end
        n_cmp++; if (miss_cnt !== m) begin n_err++; $display("FAIL abort_miss_cnt: got %0d want %0d", miss_cnt, m); end
        pix();
        n_cmp++; if (cap_gld !== 1'b0) begin n_err++; $display("FAIL restart_pf_gld: got %b want 0", cap_gld); end
        n_cmp++; if (cap_mvp !== 1'b0) begin n_err++; $display("FAIL restart_pf_target: got %b want 0", cap_mvp); end
        n_cmp++; if (cap_mghf !== 1'b1) begin n_err++; $display("FAIL restart_pf_mghf: got %b want 1", cap_mghf); end
        n_cmp++; if (mo_ack_cnt !== ma) begin n_err++; $display("FAIL abort_mo_acks: got %0d want %0d", mo_ack_cnt, ma); end
        n_cmp++; if (miss_cnt !== m + 8'd1) begin n_err++; $display("FAIL restart_miss_cnt: got %0d want %0d", miss_cnt, m + 8'd1); end
    endtask

    task automatic test_same_cycle();
        int s;
        int pa;
        // Phase 4 -> 7 with no boundaries.
        for (int i = 0; i < 3; i++) pix();
        s  = strobe_cnt;
        pa = pf_ack_cnt;
        pf_req     = 1'b1;
        pf_addr    = 18'h3FFFF;
        pf_flip    = 1'b0;
        line_start = 1'b1;
        pix_en     = 1'b1;
        tick();
        line_start = 1'b0;
        pix_en     = 1'b0;
        pf_req     = 1'b0;
        n_cmp++; if (gld_b !== 1'b1) begin n_err++; $display("FAIL same_no_mo_strobe: got %b want 1", gld_b); end
        n_cmp++; if (pf_ack !== 1'b1) begin n_err++; $display("FAIL same_pf_ack: got %b want 1", pf_ack); end
        n_cmp++; if (rom_addr !== 18'h3FFFF) begin n_err++; $display("FAIL same_rom_addr: got %h want 3ffff", rom_addr); end
        tick();
        tick();
        for (int i = 0; i < 3; i++) pix();
        n_cmp++; if (strobe_cnt !== s) begin n_err++; $display("FAIL same_phase_zero: got %0d want %0d", strobe_cnt, s); end
        pix();
        n_cmp++; if (cap_gld !== 1'b0) begin n_err++; $display("FAIL same_pf_strobe: got %b want 0", cap_gld); end
        n_cmp++; if (cap_mvp !== 1'b0) begin n_err++; $display("FAIL same_pf_target: got %b want 0", cap_mvp); end
        n_cmp++; if (pf_ack_cnt !== pa + 1) begin n_err++; $display("FAIL same_single_ack: got %0d want %0d", pf_ack_cnt, pa + 1); end
    endtask

    task automatic test_saturate_and_reset();
        int s;
        for (int i = 0; i < 1200; i++) pix();
        n_cmp++; if (miss_cnt !== 8'd255) begin n_err++; $display("FAIL miss_saturate: got %0d want 255", miss_cnt); end
        pix();
        pix();
        rst = 1'b1;
        tick();
        n_cmp++; if (gld_b !== 1'b1) begin n_err++; $display("FAIL midrst_gld_b: got %b want 1", gld_b); end
        n_cmp++; if (rom_addr !== 18'h0) begin n_err++; $display("FAIL midrst_rom_addr: got %h want 0", rom_addr); end
        n_cmp++; if (miss_cnt !== 8'd0) begin n_err++; $display("FAIL midrst_miss_cnt: got %0d want 0", miss_cnt); end
        n_cmp++; if (mo_v_pf_b !== 1'b0) begin n_err++; $display("FAIL midrst_mo_v_pf_b: got %b want 0", mo_v_pf_b); end
        n_cmp++; if (mghf !== 1'b0) begin n_err++; $display("FAIL midrst_mghf: got %b want 0", mghf); end
        n_cmp++; if (pf_blank !== 1'b1) begin n_err++; $display("FAIL midrst_pf_blank: got %b want 1", pf_blank); end
        n_cmp++; if (mo_blank !== 1'b1) begin n_err++; $display("FAIL midrst_mo_blank: got %b want 1", mo_blank); end
        rst = 1'b0;
        tick();
        s = strobe_cnt;
        for (int i = 0; i < 8; i++) pix();
        n_cmp++; if (strobe_cnt !== s) begin n_err++; $display("FAIL midrst_not_running: got %0d want %0d", strobe_cnt, s); end
    endtask

    initial begin
        rst        = 1'b1;
        pix_en     = 1'b0;
        line_start = 1'b0;
        pf_req     = 1'b0;
        pf_addr    = '0;
        pf_flip    = 1'b0;
        mo_req     = 1'b0;
        mo_addr    = '0;
        mo_flip    = 1'b0;
        test_reset();
        test_pf_fetch();
        test_mo_fetch();
        test_blank_groups();
        test_line_start_abort();
        test_same_cycle();
        test_saturate_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
